pipelined_adder: RTL and testbench

- Parametrised, pipelined add/subtract unit; successor to the fixed 16-bit combinational `adder` in the CPU datapath.
- Splits the carry chain into CHUNK-bit slices, one slice per pipeline stage, so wide operands close timing.
- Adds a valid/ready handshake with full-pipeline backpressure, add/sub select, wrap or saturating modes, and NZCV flags.
- Feeds the ALU result mux and the address-generation path.

---
 rtl/adder_pkg.sv | 11 +
 rtl/pipelined_adder_if.sv | 9 +
 rtl/adder_chunk.sv | 10 +
 rtl/pipelined_adder.sv | 92 +++++++++
 tb/tb_pipelined_adder.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared types for the pipelined add/subtract unit
package adder_pkg;
  typedef enum logic [1:0] {SAT_WRAP = 2'b00, SAT_UNS = 2'b01, SAT_SGN = 2'b10} sat_mode_e;
  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;
endpackage

// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand/result handshake bundle for pipelined_adder
interface pipelined_adder_if #(parameter int WIDTH = 16);
  logic in_valid, in_ready, out_valid, out_ready, op;
  logic [WIDTH-1:0] a, b, y;
  logic [1:0] sat_mode;
  adder_pkg::flags_t flags;
  modport master (output in_valid, a, b, op, sat_mode, out_ready, input in_ready, out_valid, y, flags);
  modport slave (input in_valid, a, b, op, sat_mode, out_ready, output in_ready, out_valid, y, flags);
endinterface

// File: rtl/adder_chunk.sv
// adder_chunk: combinational CHUNK-bit adder slice with carry in/out
module adder_chunk #(parameter int CHUNK = 8) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: add/sub split into CHUNK-bit carry stages, then a saturating
// output register; every stage and the output share one advance enable.
module pipelined_adder import adder_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 8
) (
  input logic clk,
  input logic rst_n,
  pipelined_adder_if.slave bus
);
  localparam int NSTAGE = (WIDTH / CHUNK < 1) ? 1 : WIDTH / CHUNK;
  logic adv;
  assign adv = !bus.out_valid | bus.out_ready;
  assign bus.in_ready = adv;
  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    logic [WIDTH-1:0] ra, rb, rs, pa, pb, ps, ns;
    logic rc, rop, rv, pc, pop, pv, co;
    logic [1:0] rm, pm;
    logic [CHUNK-1:0] sum;
    if (k == 0) begin : g_in
      // b is inverted once here so later stages only ever add
      assign pa = bus.a;
      assign pb = bus.op ? ~bus.b : bus.b;
      assign ps = '0;
      assign pc = bus.op;
      assign pop = bus.op;
      assign pv = bus.in_valid;
      assign pm = bus.sat_mode;
    end else begin : g_mid
      assign pa = g_stage[k-1].ra;
      assign pb = g_stage[k-1].rb;
      assign ps = g_stage[k-1].rs;
      assign pc = g_stage[k-1].rc;
      assign pop = g_stage[k-1].rop;
      assign pv = g_stage[k-1].rv;
      assign pm = g_stage[k-1].rm;
    end
    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a(pa[k*CHUNK +: CHUNK]), .b(pb[k*CHUNK +: CHUNK]), .cin(pc), .s(sum), .cout(co)
    );
    always_comb begin
      ns = ps;
      ns[k*CHUNK +: CHUNK] = sum;
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        ra <= '0;
        rb <= '0;
        rs <= '0;
        rc <= 1'b0;
        rop <= 1'b0;
        rv <= 1'b0;
        rm <= '0;
      end else if (adv) begin
        ra <= pa;
        rb <= pb;
        rs <= ns;
        rc <= co;
        rop <= pop;
        rv <= pv;
        rm <= pm;
      end
  end
  logic [WIDTH-1:0] fa, fb, fs, sy;
  logic fc, fop, fv, ov;
  logic [1:0] fm;
  assign fa = g_stage[NSTAGE-1].ra;
  assign fb = g_stage[NSTAGE-1].rb;
  assign fs = g_stage[NSTAGE-1].rs;
  assign fc = g_stage[NSTAGE-1].rc;
  assign fop = g_stage[NSTAGE-1].rop;
  assign fv = g_stage[NSTAGE-1].rv;
  assign fm = g_stage[NSTAGE-1].rm;
  assign ov = (fa[WIDTH-1] == fb[WIDTH-1]) && (fs[WIDTH-1] != fa[WIDTH-1]);
  always_comb
    sy = (fm == SAT_UNS && fop == OP_ADD && fc) ? '1 :
         (fm == SAT_UNS && fop == OP_SUB && !fc) ? '0 :
         (fm == SAT_SGN && ov) ? {fa[WIDTH-1], {(WIDTH-1){!fa[WIDTH-1]}}} : fs;
  // bubbles leave y/flags untouched so the last result stays observable
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.y <= '0;
      bus.flags <= '0;
    end else if (adv) begin
      bus.out_valid <= fv;
      if (fv) begin
        bus.y <= sy;
        bus.flags <= {sy[WIDTH-1], ~|sy, fc, ov};
      end
    end
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed vectors plus a scoreboarded random stream
module tb_pipelined_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [19:0] sb[$];
  pipelined_adder_if #(.WIDTH(16)) bif ();
  pipelined_adder #(.WIDTH(16), .CHUNK(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference built from integer arithmetic, returns {flags, y}
  function automatic logic [19:0] model(input logic [15:0] a, b, input logic op, input logic [1:0] m);
    int t, u;
    logic [15:0] y;
    logic c, v;
    t = op ? $signed(a) - $signed(b) : $signed(a) + $signed(b);
    u = op ? int'(a) - int'(b) : int'(a) + int'(b);
    c = op ? (a >= b) : (u > 65535);
    v = (t > 32767) || (t < -32768);
    y = u[15:0];
    if (m == 2'b01 && !op && c) y = 16'hFFFF;
    if (m == 2'b01 && op && !c) y = 16'h0000;
    if (m == 2'b10 && v) y = (t > 0) ? 16'h7FFF : 16'h8000;
    return {y[15], y == 16'h0, c, v, y};
  endfunction

  task automatic single(input string tag, input logic [15:0] a, b, input logic op,
                        input logic [1:0] m, input logic [15:0] ey, input logic [3:0] ef);
    bif.a = a;
    bif.b = b;
    bif.op = op;
    bif.sat_mode = m;
    bif.in_valid = 1'b1;
    step();
    bif.in_valid = 1'b0;
    step();
    chk({tag, "_early"}, 32'(bif.out_valid), 0);
    step();
    chk({tag, "_valid"}, 32'(bif.out_valid), 1);
    chk({tag, "_y"}, 32'(bif.y), 32'(ey));
    chk({tag, "_flags"}, 32'(bif.flags), 32'(ef));
    step();
  endtask

  initial begin
    int cyc, seen, sent;
    logic [19:0] e;
    bif.in_valid = 1'b0;
    bif.out_ready = 1'b1;
    bif.a = '0;
    bif.b = '0;
    bif.op = 1'b0;
    bif.sat_mode = 2'b00;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst_y", 32'(bif.y), 0);
    chk("rst_flags", 32'(bif.flags), 0);
    chk("rst_out_valid", 32'(bif.out_valid), 0);
    chk("rst_in_ready", 32'(bif.in_ready), 1);

    single("add1", 16'd1000, 16'd333, 1'b0, 2'b00, 16'd1333, 4'b0000);
    single("add2", 16'd250, 16'd1500, 1'b0, 2'b00, 16'd1750, 4'b0000);
    single("chunk_carry", 16'h00FF, 16'h0001, 1'b0, 2'b00, 16'h0100, 4'b0000);
    single("wrap_ffff", 16'hFFFF, 16'h0001, 1'b0, 2'b00, 16'h0000, 4'b0110);
    single("usat_ffff", 16'hFFFF, 16'h0001, 1'b0, 2'b01, 16'hFFFF, 4'b1010);
    single("rsvd_ffff", 16'hFFFF, 16'h0001, 1'b0, 2'b11, 16'h0000, 4'b0110);
    single("sub_wrap", 16'h8000, 16'h0001, 1'b1, 2'b00, 16'h7FFF, 4'b0011);
    single("sub_ssat", 16'h8000, 16'h0001, 1'b1, 2'b10, 16'h8000, 4'b1011);
    single("sub_2_1", 16'd2, 16'd1, 1'b1, 2'b00, 16'd1, 4'b0010);
    single("usat_sub", 16'd1, 16'd2, 1'b1, 2'b01, 16'h0000, 4'b0100);
    single("ssat_pos", 16'h7FFF, 16'h0001, 1'b0, 2'b10, 16'h7FFF, 4'b0001);

    // backpressure: three beats into a stalled output
    bif.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bif.a = 16'(i + 1);
      bif.b = 16'h0100;
      bif.op = 1'b0;
      bif.sat_mode = 2'b00;
      bif.in_valid = 1'b1;
      step();
    end
    bif.in_valid = 1'b0;
    chk("bp_valid", 32'(bif.out_valid), 1);
    chk("bp_in_ready", 32'(bif.in_ready), 0);
    chk("bp_y0", 32'(bif.y), 32'h0101);
    repeat (3) step();
    chk("bp_hold_valid", 32'(bif.out_valid), 1);
    chk("bp_hold_y", 32'(bif.y), 32'h0101);
    bif.out_ready = 1'b1;
    step();
    chk("bp_y1_valid", 32'(bif.out_valid), 1);
    chk("bp_y1", 32'(bif.y), 32'h0102);
    step();
    chk("bp_y2_valid", 32'(bif.out_valid), 1);
    chk("bp_y2", 32'(bif.y), 32'h0103);
    step();
    chk("bp_drained", 32'(bif.out_valid), 0);

    // reset while beats are in flight
    for (int i = 0; i < 3; i++) begin
      bif.a = 16'(i + 16'h0040);
      bif.b = 16'h0001;
      bif.in_valid = 1'b1;
      step();
    end
    bif.in_valid = 1'b0;
    chk("mid_pre_valid", 32'(bif.out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bif.out_valid), 0);
    step();
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      step();
      if (bif.out_valid) seen++;
    end
    chk("mid_rst_no_ghost", 32'(seen), 0);

    // random stream with scoreboard
    sent = 0;
    cyc = 0;
    while ((sent < 100 || sb.size() != 0) && cyc < 3000) begin
      bif.in_valid = (sent < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
      bif.out_ready = 1'($urandom_range(0, 1));
      bif.a = 16'($urandom);
      bif.b = 16'($urandom);
      bif.op = 1'($urandom_range(0, 1));
      bif.sat_mode = 2'($urandom_range(0, 3));
      #3;
      if (bif.in_valid && bif.in_ready) begin
        sb.push_back(model(bif.a, bif.b, bif.op, bif.sat_mode));
        sent++;
      end
      if (bif.out_valid && bif.out_ready) begin
        if (sb.size() == 0) chk("stream_underflow", 32'(sb.size()), 1);
        else begin
          e = sb.pop_front();
          chk("stream_result", {12'h0, bif.flags, bif.y}, {12'h0, e});
        end
      end
      step();
      cyc++;
    end
    chk("stream_done", 32'(cyc < 3000), 1);

    // full throughput with both handshakes held high
    seen = 0;
    bif.out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      bif.in_valid = 1'b1;
      bif.a = 16'($urandom);
      bif.b = 16'($urandom);
      bif.op = 1'($urandom_range(0, 1));
      bif.sat_mode = 2'($urandom_range(0, 3));
      #3;
      if (bif.in_ready) sb.push_back(model(bif.a, bif.b, bif.op, bif.sat_mode));
      if (bif.out_valid) begin
        if (i >= 4) seen++;
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("tput_result", {12'h0, bif.flags, bif.y}, {12'h0, e});
        end
      end
      step();
    end
    chk("tput_rate", 32'(seen), 20);
    bif.in_valid = 1'b0;
    cyc = 0;
    while (sb.size() != 0 && cyc < 20) begin
      #3;
      if (bif.out_valid) begin
        e = sb.pop_front();
        chk("tput_drain", {12'h0, bif.flags, bif.y}, {12'h0, e});
      end
      step();
      cyc++;
    end
    chk("tput_drain_done", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
